// File: rtl/cpu_defs.sv
// Shared fetch-stage definitions: decoder address-select codes, the NOP word,
// the fetch FSM encoding and the prefetch FIFO entry layout.
package cpu_defs;

  localparam logic [1:0]  ADDRESS_SELECT_ALU = 2'b00;
  localparam logic [1:0]  ADDRESS_SELECT_PC  = 2'b01;
  localparam logic [1:0]  ADDRESS_SELECT_INC = 2'b10;
  localparam logic [31:0] INSTRUCTION_NOP    = 32'hE1A0_0000;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'b00,
    FETCH_REQ  = 2'b01,
    FETCH_DROP = 2'b10
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Only ALU and PC selects move the fetch stream; INC and the spare code do not.
  function automatic logic is_redirect(input logic upd, input logic [1:0] sel);
    return upd && ((sel == ADDRESS_SELECT_ALU) || (sel == ADDRESS_SELECT_PC));
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory handshake, decoder redirect/stall
// inputs and the fetch->decode instruction outputs.
interface instruction_fetch_unit_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        de_addreg_update;
  logic [1:0]  de_addreg_sel;
  logic [31:0] alu_result;
  logic [31:0] pc_value;
  logic        de_stall;
  logic [31:0] fd_instruction;
  logic [31:0] fd_pc;
  logic        fd_valid;

  modport master (
    output mem_req, mem_addr, fd_instruction, fd_pc, fd_valid,
    input  mem_ack, mem_rdata, de_addreg_update, de_addreg_sel,
           alu_result, pc_value, de_stall
  );

  modport slave (
    input  mem_req, mem_addr, fd_instruction, fd_pc, fd_valid,
    output mem_ack, mem_rdata, de_addreg_update, de_addreg_sel,
           alu_result, pc_value, de_stall
  );
endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO, DEPTH entries (power of two); head is combinational, push lands next cycle.
// Flush beats push; a push while full is only taken when a pop frees the slot in the same cycle.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic                         i_flush,
  input  logic [WIDTH-1:0]             i_wr_dat,
  output logic [WIDTH-1:0]             o_rd_dat,
  output logic [$clog2(DEPTH):0]       o_count,
  output logic                         o_empty,
  output logic                         o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign o_rd_dat  = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_wr_dat;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: one outstanding memory read, words buffered in fetch_fifo; ack-to-fd_ latency 1 cycle.
// Decoder stall holds the FIFO head; fetching pauses when the FIFO would overflow.
module instruction_fetch_unit
  import cpu_defs::*;
#(
  parameter int          FIFO_DEPTH   = 2,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      reset,
  instruction_fetch_unit_if.master  bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] LP_DEPTH_M1 = CW'(FIFO_DEPTH - 1);

  fetch_state_t  r_state;
  logic [31:0]   r_fetch_addr;
  logic [31:0]   r_last_pc;
  logic          r_mem_req;
  logic [31:0]   r_mem_addr;

  logic          w_redirect;
  logic [31:0]   w_target;
  logic          w_ack;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic          w_full;
  logic [CW-1:0] w_count;
  logic          w_room_idle;
  logic          w_room_req;
  fetch_entry_t  w_wr;
  fetch_entry_t  w_head;

  assign w_redirect = is_redirect(bus.de_addreg_update, bus.de_addreg_sel);
  assign w_target   = ((bus.de_addreg_sel == ADDRESS_SELECT_PC) ? bus.pc_value : bus.alu_result)
                      & 32'hFFFF_FFFC;
  assign w_ack      = bus.mem_ack && r_mem_req;
  // A redirect flushes the FIFO, so it also swallows any same-cycle push or pop.
  assign w_push     = (r_state == FETCH_REQ) && w_ack && !w_redirect;
  assign w_pop      = !w_empty && !bus.de_stall && !w_redirect;
  assign w_wr       = '{pc: r_fetch_addr, instr: bus.mem_rdata};

  assign w_room_idle = !w_full || w_pop;
  assign w_room_req  = (w_count < LP_DEPTH_M1) || w_pop;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_flush  (w_redirect),
    .i_wr_dat (w_wr),
    .o_rd_dat (w_head),
    .o_count  (w_count),
    .o_empty  (w_empty),
    .o_full   (w_full)
  );

  assign bus.mem_req        = r_mem_req;
  assign bus.mem_addr       = r_mem_addr;
  assign bus.fd_valid       = !w_empty;
  assign bus.fd_instruction = w_empty ? INSTRUCTION_NOP : w_head.instr;
  assign bus.fd_pc          = w_empty ? r_last_pc : w_head.pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= FETCH_IDLE;
      r_fetch_addr <= RESET_VECTOR;
      r_last_pc    <= RESET_VECTOR;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= RESET_VECTOR;
    end else begin
      if (w_push) r_last_pc <= r_fetch_addr;
      case (r_state)
        FETCH_IDLE: begin
          if (w_redirect) begin
            r_fetch_addr <= w_target;
            r_mem_addr   <= w_target;
            r_mem_req    <= 1'b1;
            r_state      <= FETCH_REQ;
          end else if (w_room_idle) begin
            r_mem_addr   <= r_fetch_addr;
            r_mem_req    <= 1'b1;
            r_state      <= FETCH_REQ;
          end
        end
        FETCH_REQ: begin
          if (w_redirect) begin
            r_fetch_addr <= w_target;
            if (w_ack) r_mem_addr <= w_target;
            else       r_state    <= FETCH_DROP;
          end else if (w_ack) begin
            r_fetch_addr <= r_fetch_addr + 32'd4;
            if (w_room_req) begin
              r_mem_addr <= r_fetch_addr + 32'd4;
            end else begin
              r_mem_req  <= 1'b0;
              r_state    <= FETCH_IDLE;
            end
          end
        end
        FETCH_DROP: begin
          // The stale request stays on the bus until acked; r_fetch_addr already holds the target.
          if (w_redirect) r_fetch_addr <= w_target;
          if (w_ack) begin
            r_mem_addr <= w_redirect ? w_target : r_fetch_addr;
            r_state    <= FETCH_REQ;
          end
        end
        default: begin
          r_mem_req <= 1'b0;
          r_state   <= FETCH_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: memory model answers rdata = addr ^ 32'hA5A5_0000.
module tb_instruction_fetch_unit;
  import cpu_defs::*;

  logic clk;
  logic reset;
  logic ack_en;
  int   n_cmp;
  int   n_fail;

  instruction_fetch_unit_if bus();

  instruction_fetch_unit #(
    .FIFO_DEPTH   (2),
    .RESET_VECTOR (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  assign bus.mem_ack   = ack_en && bus.mem_req;
  assign bus.mem_rdata = bus.mem_addr ^ 32'hA5A5_0000;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b1;
    ack_en = 1'b0;
    bus.de_addreg_update = 1'b0;
    bus.de_addreg_sel    = 2'b00;
    bus.alu_result       = 32'h0;
    bus.pc_value         = 32'h0;
    bus.de_stall         = 1'b0;

    #2;
    chk("rst_mem_req",  {31'd0, bus.mem_req},  32'd0);
    chk("rst_mem_addr", bus.mem_addr,          32'h0);
    chk("rst_fd_valid", {31'd0, bus.fd_valid}, 32'd0);
    chk("rst_fd_instr", bus.fd_instruction,    INSTRUCTION_NOP);
    chk("rst_fd_pc",    bus.fd_pc,             32'h0);
    tick();
    tick();
    reset  = 1'b0;
    ack_en = 1'b1;

    // Streaming after reset
    tick();
    chk("c1_mem_req",  {31'd0, bus.mem_req},  32'd1);
    chk("c1_mem_addr", bus.mem_addr,          32'h0);
    chk("c1_fd_valid", {31'd0, bus.fd_valid}, 32'd0);
    tick();
    chk("c2_fd_valid", {31'd0, bus.fd_valid}, 32'd1);
    chk("c2_fd_pc",    bus.fd_pc,             32'h0);
    chk("c2_fd_instr", bus.fd_instruction,    32'hA5A5_0000);
    chk("c2_mem_addr", bus.mem_addr,          32'h4);
    tick();
    chk("c3_fd_pc",    bus.fd_pc,             32'h4);
    chk("c3_fd_instr", bus.fd_instruction,    32'hA5A5_0004);
    chk("c3_mem_addr", bus.mem_addr,          32'h8);

    // Stall: FIFO fills to two, request drops
    bus.de_stall = 1'b1;
    tick();
    chk("st1_mem_req", {31'd0, bus.mem_req},  32'd0);
    chk("st1_fd_pc",   bus.fd_pc,             32'h4);
    tick();
    chk("st2_mem_req", {31'd0, bus.mem_req},  32'd0);
    chk("st2_fd_pc",   bus.fd_pc,             32'h4);
    chk("st2_fd_valid",{31'd0, bus.fd_valid}, 32'd1);
    bus.de_stall = 1'b0;
    tick();
    chk("rl1_fd_pc",   bus.fd_pc,             32'h8);
    chk("rl1_mem_req", {31'd0, bus.mem_req},  32'd1);
    chk("rl1_mem_addr",bus.mem_addr,          32'hC);
    tick();
    chk("rl2_fd_pc",   bus.fd_pc,             32'hC);
    chk("rl2_fd_instr",bus.fd_instruction,    32'hA5A5_000C);
    chk("rl2_mem_addr",bus.mem_addr,          32'h10);

    // ALU redirect with request outstanding, ack delayed three cycles
    ack_en = 1'b0;
    bus.de_addreg_update = 1'b1;
    bus.de_addreg_sel    = ADDRESS_SELECT_ALU;
    bus.alu_result       = 32'h0000_0103;
    tick();
    bus.de_addreg_update = 1'b0;
    chk("dr1_fd_valid", {31'd0, bus.fd_valid}, 32'd0);
    chk("dr1_mem_req",  {31'd0, bus.mem_req},  32'd1);
    chk("dr1_mem_addr", bus.mem_addr,          32'h10);
    tick();
    chk("dr2_mem_addr", bus.mem_addr,          32'h10);
    chk("dr2_fd_valid", {31'd0, bus.fd_valid}, 32'd0);
    tick();
    chk("dr3_mem_addr", bus.mem_addr,          32'h10);
    ack_en = 1'b1;
    tick();
    chk("dr4_mem_addr", bus.mem_addr,          32'h100);
    chk("dr4_fd_valid", {31'd0, bus.fd_valid}, 32'd0);
    tick();
    chk("dr5_fd_valid", {31'd0, bus.fd_valid}, 32'd1);
    chk("dr5_fd_pc",    bus.fd_pc,             32'h100);
    chk("dr5_fd_instr", bus.fd_instruction,    32'hA5A5_0100);
    chk("dr5_mem_addr", bus.mem_addr,          32'h104);

    // PC redirect in the same cycle as an ack
    bus.de_addreg_update = 1'b1;
    bus.de_addreg_sel    = ADDRESS_SELECT_PC;
    bus.pc_value         = 32'h40;
    tick();
    bus.de_addreg_update = 1'b0;
    chk("pr1_fd_valid", {31'd0, bus.fd_valid}, 32'd0);
    chk("pr1_mem_addr", bus.mem_addr,          32'h40);
    tick();
    chk("pr2_fd_valid", {31'd0, bus.fd_valid}, 32'd1);
    chk("pr2_fd_pc",    bus.fd_pc,             32'h40);
    chk("pr2_mem_addr", bus.mem_addr,          32'h44);

    // INC and spare select do not redirect
    bus.de_addreg_update = 1'b1;
    bus.de_addreg_sel    = ADDRESS_SELECT_INC;
    bus.alu_result       = 32'h200;
    bus.pc_value         = 32'h300;
    tick();
    chk("inc_fd_valid", {31'd0, bus.fd_valid}, 32'd1);
    chk("inc_fd_pc",    bus.fd_pc,             32'h44);
    chk("inc_mem_addr", bus.mem_addr,          32'h48);
    bus.de_addreg_sel    = 2'b11;
    tick();
    chk("s11_fd_pc",    bus.fd_pc,             32'h48);
    chk("s11_mem_addr", bus.mem_addr,          32'h4C);
    bus.de_addreg_update = 1'b0;

    // Wrap of the fetch address past the top of memory
    bus.de_addreg_update = 1'b1;
    bus.de_addreg_sel    = ADDRESS_SELECT_ALU;
    bus.alu_result       = 32'hFFFF_FFFF;
    tick();
    bus.de_addreg_update = 1'b0;
    chk("wr1_mem_addr", bus.mem_addr,          32'hFFFF_FFFC);
    chk("wr1_fd_valid", {31'd0, bus.fd_valid}, 32'd0);
    tick();
    chk("wr2_mem_addr", bus.mem_addr,          32'h0);
    chk("wr2_fd_pc",    bus.fd_pc,             32'hFFFF_FFFC);
    chk("wr2_fd_instr", bus.fd_instruction,    32'h5A5A_FFFC);
    tick();
    chk("wr3_fd_pc",    bus.fd_pc,             32'h0);
    chk("wr3_mem_addr", bus.mem_addr,          32'h4);

    // Asynchronous reset in the middle of a request
    ack_en = 1'b0;
    #2;
    chk("ar0_mem_req",  {31'd0, bus.mem_req},  32'd1);
    reset = 1'b1;
    #1;
    chk("ar_mem_req",   {31'd0, bus.mem_req},  32'd0);
    chk("ar_fd_valid",  {31'd0, bus.fd_valid}, 32'd0);
    chk("ar_mem_addr",  bus.mem_addr,          32'h0);
    #2;
    reset  = 1'b0;
    ack_en = 1'b1;
    tick();
    chk("ar1_mem_req",  {31'd0, bus.mem_req},  32'd1);
    chk("ar1_mem_addr", bus.mem_addr,          32'h0);
    tick();
    chk("ar2_fd_valid", {31'd0, bus.fd_valid}, 32'd1);
    chk("ar2_fd_pc",    bus.fd_pc,             32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage feeding the instruction decoder.
- Issues instruction-memory reads through a req/ack handshake and buffers returned words in a small prefetch FIFO.
- Presents them as fd_instruction/fd_valid/fd_pc.
- Redirects the fetch stream when the decoder signals a PC write via de_addreg_update/de_addreg_sel.

Parameters:
- FIFO_DEPTH, 2, prefetch entries (power of two, >=2).
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_req  out  1  read request, registered.
- mem_addr  out  32  word-aligned read address, registered.
- mem_ack  in  1  memory accepted request; mem_rdata valid in the same cycle.
- mem_rdata  in  32  instruction word.
- de_addreg_update  in  1  decoder requests fetch-address update.
- de_addreg_sel  in  2  00 = ALU, 01 = PC, 10 = INC.
- alu_result  in  32  redirect target for ALU select.
- pc_value  in  32  redirect target for PC select.
- de_stall  in  1  decoder cannot consume this cycle.
- fd_instruction  out  32  head instruction, or NOP 32'hE1A0_0000 when empty.
- fd_pc  out  32  address of fd_instruction.
- fd_valid  out  1  FIFO head valid.

Behaviour:
- Reset (async, any time, including mid-request):
  - mem_req = 0, mem_addr = RESET_VECTOR, FIFO flushed.
  - fd_valid = 0, fd_instruction = NOP, fd_pc = RESET_VECTOR.
  - State = IDLE, fetch_addr = RESET_VECTOR.
- States:
  - IDLE: no request outstanding. Go to REQ with mem_req = 1 and mem_addr = fetch_addr when (count + 0) < FIFO_DEPTH after this cycle's pop.
  - REQ: mem_req and mem_addr are held stable until mem_ack.
    - On ack: push {fetch_addr, mem_rdata} and set fetch_addr += 4. Stay in REQ with the new address if space remains after push/pop; otherwise go to IDLE with mem_req = 0.
  - DROP: a redirect arrived while a request was outstanding. mem_req and mem_addr stay held. On ack, discard data, then issue at the redirect target (REQ) or go to IDLE.
- Redirect: de_addreg_update = 1 with sel ALU or PC.
  - Flush the FIFO in the same edge; fd_valid = 0 next cycle.
  - fetch_addr = target with bits[1:0] forced to 0.
  - If state is REQ without ack this cycle -> DROP.
  - If state is REQ with ack this cycle -> acked data discarded; go to REQ at the target.
- sel = INC, sel = 11, or update = 0: no redirect.
- Redirect plus pop in the same cycle: the pop is ignored (flush wins).
- Consume: pop when fd_valid && !de_stall. Push and pop in the same cycle are both legal when full.
- Address arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- Latency: with ack in the cycle of request, the instruction is visible on fd_ the next cycle. Throughput is 1 instruction/cycle when there is no stall.
- At most one outstanding request. Occupancy never exceeds FIFO_DEPTH.
- fd_instruction and fd_pc come combinationally from the FIFO head. When empty they show NOP and the last fetched PC.

Decomposition:
- Package cpu_defs: ADDRESS_SELECT_ALU/PC/INC, INSTRUCTION_NOP, fetch state encoding.
- Sub-module fetch_fifo: synchronous FIFO with parameter depth. Width 64 ({pc, instr}); push/pop/flush; count, empty and full outputs. Flush has priority over push.

Test Plan:
- Reset release, memory acks every cycle with rdata = addr ^ 32'hA5A5_0000 -> mem_addr 0, 4, 8 ... on consecutive cycles; fd_pc 0 with fd_valid at cycle 2, then one word per cycle.
- de_stall held high, acks always -> exactly 2 words buffered, mem_req drops. Release stall -> words popped in order with no duplicate or lost addresses.
- Redirect sel = ALU, alu_result = 32'h0000_0103, while a request is outstanding and ack delayed 3 cycles -> mem_addr held, acked word dropped, next request to 32'h100, FIFO empty until that ack.
- Redirect sel = PC, pc_value = 32'h40, in the same cycle as ack -> acked word discarded, next mem_addr = 32'h40, fd_valid = 0 for one cycle.
- Reset asserted mid-REQ with mem_req = 1 -> mem_req = 0 immediately (async), fd_valid = 0. After release the first request is at RESET_VECTOR.
- fetch_addr 32'hFFFF_FFFC with acks -> next mem_addr = 32'h0000_0000. sel = INC with update = 1 -> no flush.
